// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Purpose : groups the pixel-rate strobe and all raster timing outputs of
//           vga_timing_gen into one bundle.
// Modports:
//   master - the timing generator: takes pixel_en, drives everything else
//   slave  - the consumer (pixel pipeline / pads): drives pixel_en, reads
//            counters, syncs, draw, line/frame markers and frame_count
// Signals :
//   pixel_en       pixel-rate strobe, counters advance only when high
//   h_count        current column (CNT_W bits)
//   v_count        current line   (CNT_W bits)
//   h_sync_signal  horizontal sync at its configured polarity
//   v_sync_signal  vertical sync at its configured polarity
//   draw           visible-area flag
//   line_start     high at column 0
//   frame_start    high at column 0 of line 0
//   frame_count    completed-frame counter (16 bits)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             pixel_en;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_sync_signal;
    logic             v_sync_signal;
    logic             draw;
    logic             line_start;
    logic             frame_start;
    logic [15:0]      frame_count;

    modport master (
        input  pixel_en,
        output h_count, v_count, h_sync_signal, v_sync_signal,
        output draw, line_start, frame_start, frame_count
    );

    modport slave (
        output pixel_en,
        input  h_count, v_count, h_sync_signal, v_sync_signal,
        input  draw, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Purpose : parametrised VGA raster timing generator (default 640x480@60,
//           800x525 total). Line and frame order: active, front porch,
//           sync, back porch. The raster advances only on pixel_en strobes.
// Ports   :
//   pixelClock  system clock
//   reset       asynchronous, active-high reset (restarts at column 0, line 0)
//   vga         vga_timing_gen_if.master: pixel_en in; h_count, v_count,
//               h_sync_signal, v_sync_signal, draw, line_start, frame_start,
//               frame_count out
// Options :
//   VGA_FRAME_COUNT_EN - when defined, frame_count counts completed frames
//                        (wrapping at 16'hFFFF); when undefined frame_count
//                        is tied to zero and no counter register exists.
// All outputs are registered and decoded from the next counter values, so
// they line up with h_count/v_count in the same cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 11
) (
    input  logic                pixelClock,
    input  logic                reset,
    vga_timing_gen_if.master    vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_count_d, h_count_q;
    logic [CNT_W-1:0] v_count_d, v_count_q;
    logic             h_sync_d, h_sync_q;
    logic             v_sync_d, v_sync_q;
    logic             draw_d, draw_q;
    logic             line_start_d, line_start_q;
    logic             frame_start_d, frame_start_q;

    // Next raster position: step on a strobe, wrap the column and then the line.
    always_comb begin
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (vga.pixel_en) begin
            if (h_count_q == H_LAST_C) begin
                h_count_d = ZERO_C;
                if (v_count_q == V_LAST_C) begin
                    v_count_d = ZERO_C;
                end else begin
                    v_count_d = v_count_q + ONE_C;
                end
            end else begin
                h_count_d = h_count_q + ONE_C;
            end
        end else begin
            h_count_d = h_count_q;
            v_count_d = v_count_q;
        end
    end

    // Decode markers from the next position so the registered copies line up
    // with the registered counters; with pixel_en low they simply hold.
    always_comb begin
        draw_d        = (h_count_d < H_ACT_C) && (v_count_d < V_ACT_C);
        line_start_d  = (h_count_d == ZERO_C);
        frame_start_d = (h_count_d == ZERO_C) && (v_count_d == ZERO_C);
        h_sync_d      = ((h_count_d >= HS_START_C) && (h_count_d < HS_END_C))
                        ? H_SYNC_POL : ~H_SYNC_POL;
        v_sync_d      = ((v_count_d >= VS_START_C) && (v_count_d < VS_END_C))
                        ? V_SYNC_POL : ~V_SYNC_POL;
    end

    // Raster state and output registers; reset lands on the first visible pixel.
    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            h_count_q     <= ZERO_C;
            v_count_q     <= ZERO_C;
            h_sync_q      <= ~H_SYNC_POL;
            v_sync_q      <= ~V_SYNC_POL;
            draw_q        <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            draw_q        <= draw_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.h_count       = h_count_q;
    assign vga.v_count       = v_count_q;
    assign vga.h_sync_signal = h_sync_q;
    assign vga.v_sync_signal = v_sync_q;
    assign vga.draw          = draw_q;
    assign vga.line_start    = line_start_q;
    assign vga.frame_start   = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_d, frame_count_q;
    logic        frame_wrap_s;

    // Count the strobe that takes the last pixel of the frame back to (0,0).
    always_comb begin
        frame_wrap_s = vga.pixel_en && (h_count_q == H_LAST_C) && (v_count_q == V_LAST_C);
        if (frame_wrap_s) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Completed-frame counter register.
    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            frame_count_q <= 16'h0000;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign vga.frame_count = frame_count_q;
`else
    assign vga.frame_count = 16'h0000;
`endif

endmodule
